// File: rtl/branch_target_buffer_if.sv
// -----------------------------------------------------------------------------
// branch_target_buffer_if
// Bundles the lookup, update and status signals of the branch target buffer.
//   master : fetch/resolve side (drives RdEn/RAddr and the Upd_* strobe)
//   slave  : the BTB itself (drives Hit/PC_Source/PPC_CB/Ready)
// Lookup : RdEn, RAddr -> Hit, PC_Source, PPC_CB
// Update : Upd_Valid, Upd_PC, Upd_Taken, Upd_Target
// Status : Ready, plus Stat_Lookups/Stat_Hits when BTB_STATS_EN is defined.
// -----------------------------------------------------------------------------
interface branch_target_buffer_if #(
  parameter int ADDR_W = 32
);
  logic              RdEn;
  logic [ADDR_W-1:0] RAddr;
  logic              Hit;
  logic              PC_Source;
  logic [ADDR_W+1:0] PPC_CB;
  logic              Upd_Valid;
  logic [ADDR_W-1:0] Upd_PC;
  logic              Upd_Taken;
  logic [ADDR_W-1:0] Upd_Target;
  logic              Ready;
`ifdef BTB_STATS_EN
  logic [15:0]       Stat_Lookups;
  logic [15:0]       Stat_Hits;
`endif

  modport master (
    output RdEn, RAddr, Upd_Valid, Upd_PC, Upd_Taken, Upd_Target,
    input  Hit, PC_Source, PPC_CB, Ready
`ifdef BTB_STATS_EN
    , input Stat_Lookups, Stat_Hits
`endif
  );

  modport slave (
    input  RdEn, RAddr, Upd_Valid, Upd_PC, Upd_Taken, Upd_Target,
    output Hit, PC_Source, PPC_CB, Ready
`ifdef BTB_STATS_EN
    , output Stat_Lookups, Stat_Hits
`endif
  );
endinterface

// File: rtl/branch_target_buffer.sv
// -----------------------------------------------------------------------------
// branch_target_buffer
// 2-way set-associative BTB with 2-bit direction counters and 1-bit LRU per set.
// Ports:
//   Clk  - clock, all state changes on posedge
//   Rst  - synchronous active-high reset; starts the valid/LRU clearing sweep
//   bus  - branch_target_buffer_if.slave (lookup, update, Ready, statistics)
// Lookup is combinational; updates land at the clock edge, so a same-cycle
// lookup sees the old contents.
// Optional feature: define BTB_STATS_EN to add 16-bit saturating lookup/hit
// counters on the interface.
//
// state | meaning
// CLEAR | sweeping sets, clearing valid+LRU one set per cycle; no hits, updates dropped
// READY | normal lookup/update operation
// -----------------------------------------------------------------------------
module branch_target_buffer #(
  parameter int ADDR_W = 32,
  parameter int IDX_W  = 6
) (
  input logic                 Clk,
  input logic                 Rst,
  branch_target_buffer_if.slave bus
);
  localparam int SETS  = 1 << IDX_W;
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  typedef enum logic {CLEAR, READY} state_t;

  state_t             state_q;
  logic [IDX_W-1:0]   ptr_q;
  logic               ready_q;

  // Only valid and LRU are reset by the sweep; everything else is masked by valid.
  logic               valid_q [2][SETS];
  logic [TAG_W-1:0]   tag_q   [2][SETS];
  logic [ADDR_W-1:0]  tgt_q   [2][SETS];
  logic [1:0]         cnt_q   [2][SETS];
  logic               lru_q   [SETS];

  // ---------------- lookup ----------------
  logic [IDX_W-1:0]   r_idx;
  logic [TAG_W-1:0]   r_tag;
  logic               r_m0, r_m1, hit;
  logic [ADDR_W+1:0]  ppc_cb;

  assign r_idx = bus.RAddr[IDX_W+1:2];
  assign r_tag = bus.RAddr[ADDR_W-1:IDX_W+2];

  always_comb begin
    r_m0   = valid_q[0][r_idx] && (tag_q[0][r_idx] == r_tag);
    r_m1   = valid_q[1][r_idx] && (tag_q[1][r_idx] == r_tag);
    hit    = ready_q && bus.RdEn && (r_m0 || r_m1);
    ppc_cb = '0;
    if (hit) begin
      // way0 wins a double match
      if (r_m0) ppc_cb = {tgt_q[0][r_idx], cnt_q[0][r_idx]};
      else      ppc_cb = {tgt_q[1][r_idx], cnt_q[1][r_idx]};
    end
  end

  assign bus.Hit       = hit;
  assign bus.PC_Source = hit && ppc_cb[1];
  assign bus.PPC_CB    = ppc_cb;
  assign bus.Ready     = ready_q;

  // ---------------- update decode ----------------
  logic [IDX_W-1:0]   u_idx;
  logic [TAG_W-1:0]   u_tag;
  logic               u_m0, u_m1, u_hit, u_way, victim;
  logic [1:0]         cnt_old, cnt_d;

  assign u_idx = bus.Upd_PC[IDX_W+1:2];
  assign u_tag = bus.Upd_PC[ADDR_W-1:IDX_W+2];

  always_comb begin
    u_m0    = valid_q[0][u_idx] && (tag_q[0][u_idx] == u_tag);
    u_m1    = valid_q[1][u_idx] && (tag_q[1][u_idx] == u_tag);
    u_hit   = u_m0 || u_m1;
    u_way   = u_m0 ? 1'b0 : 1'b1;
    cnt_old = cnt_q[u_way][u_idx];
    cnt_d   = cnt_old;
    if (bus.Upd_Taken) begin
      if (cnt_old != 2'b11) cnt_d = cnt_old + 2'd1;
    end else begin
      if (cnt_old != 2'b00) cnt_d = cnt_old - 2'd1;
    end
    // Fill an empty way first (way0 preferred), otherwise replace the LRU way.
    if (!valid_q[0][u_idx])      victim = 1'b0;
    else if (!valid_q[1][u_idx]) victim = 1'b1;
    else                         victim = lru_q[u_idx];
  end

  // ---------------- state ----------------
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        CLEAR: begin
          valid_q[0][ptr_q] <= 1'b0;
          valid_q[1][ptr_q] <= 1'b0;
          lru_q[ptr_q]      <= 1'b0;
          ptr_q             <= ptr_q + 1'b1;
          if (&ptr_q) begin
            state_q <= READY;
            ready_q <= 1'b1;
          end
        end
        READY: begin
          if (bus.Upd_Valid) begin
            if (u_hit) begin
              cnt_q[u_way][u_idx] <= cnt_d;
              if (bus.Upd_Taken) tgt_q[u_way][u_idx] <= bus.Upd_Target;
              lru_q[u_idx] <= ~u_way;
            end else if (bus.Upd_Taken) begin
              valid_q[victim][u_idx] <= 1'b1;
              tag_q[victim][u_idx]   <= u_tag;
              tgt_q[victim][u_idx]   <= bus.Upd_Target;
              cnt_q[victim][u_idx]   <= 2'b10;
              lru_q[u_idx]           <= ~victim;
            end
          end
        end
        default: begin
          state_q <= CLEAR;
          ptr_q   <= '0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef BTB_STATS_EN
  logic [15:0] stat_lookups_q, stat_hits_q;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      stat_lookups_q <= '0;
      stat_hits_q    <= '0;
    end else begin
      if (ready_q && bus.RdEn && (stat_lookups_q != 16'hFFFF))
        stat_lookups_q <= stat_lookups_q + 16'd1;
      if (hit && (stat_hits_q != 16'hFFFF))
        stat_hits_q <= stat_hits_q + 16'd1;
    end
  end

  assign bus.Stat_Lookups = stat_lookups_q;
  assign bus.Stat_Hits    = stat_hits_q;
`endif

  // Byte-offset bits never take part in indexing or tagging.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.RAddr[1:0], bus.Upd_PC[1:0]};

endmodule
